// File: rtl/light_pkg.sv
// Shared traffic-light definitions: colour codes on the command/status wires and lamp states.
// Also used by light_controller.
package light_pkg;

    localparam logic [1:0] COLOR_RED     = 2'd0;
    localparam logic [1:0] COLOR_YELLOW  = 2'd1;
    localparam logic [1:0] COLOR_ILLEGAL = 2'd2;
    localparam logic [1:0] COLOR_GREEN   = 2'd3;

    typedef enum logic [1:0] {
        StRed,
        StGreen,
        StYellow,
        StClear
    } lamp_state_e;

    // Red and yellow requests both mean "stop"; a stop always passes through yellow.
    function automatic logic is_stop_request(input logic [1:0] color);
        return (color == COLOR_RED) || (color == COLOR_YELLOW);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating cycle counter for state dwell times; cleared synchronously on reset or state change.
module dwell_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/light_lamp_driver.sv
// Lamp-side sequencer: red -> green -> yellow -> red with minimum/exact dwell times.
// Define LIGHT_DRV_ALL_RED_EN to insert an all-red CLEAR phase between yellow and red.
module light_lamp_driver
    import light_pkg::*;
#(
    parameter int unsigned CNT_W            = 8,
    parameter int unsigned MIN_RED_CYCLES   = 2,
    parameter int unsigned MIN_GREEN_CYCLES = 8,
    parameter int unsigned YELLOW_CYCLES    = 4,
    parameter int unsigned CLEAR_CYCLES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] set_light_color,
    output logic [1:0] current_light_state,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       busy,
    output logic       cmd_err
);

    localparam longint unsigned CntLimit = 64'd1 << CNT_W;
    localparam bit ParamsOk =
        (MIN_RED_CYCLES   >= 1) && (64'(MIN_RED_CYCLES)   < CntLimit) &&
        (MIN_GREEN_CYCLES >= 1) && (64'(MIN_GREEN_CYCLES) < CntLimit) &&
        (YELLOW_CYCLES    >= 1) && (64'(YELLOW_CYCLES)    < CntLimit) &&
        (CLEAR_CYCLES     >= 1) && (64'(CLEAR_CYCLES)     < CntLimit);

    if (!ParamsOk) begin : g_bad_params
        $error("light_lamp_driver: dwell parameters must be >= 1 and < 2**CNT_W");
    end

    // Last dwell value of a state: dwell counts 0..N-1 over N visible cycles.
    localparam logic [CNT_W-1:0] RedLast    = CNT_W'(MIN_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYCLES - 1);
`ifdef LIGHT_DRV_ALL_RED_EN
    localparam logic [CNT_W-1:0] ClearLast  = CNT_W'(CLEAR_CYCLES - 1);
`endif

    lamp_state_e      state_q, state_d;
    logic [CNT_W-1:0] dwell;
    logic             state_change;

    logic [1:0] color_d;
    logic       red_d, yellow_d, green_d, busy_d;

    assign state_change = (state_d != state_q);

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state_change),
        .count (dwell)
    );

    // Illegal code 2 matches none of the transition conditions, so it acts as a hold.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = StRed;
        end else begin
            unique case (state_q)
                StRed: begin
                    if (set_light_color == COLOR_GREEN && dwell >= RedLast) begin
                        state_d = StGreen;
                    end
                end
                StGreen: begin
                    if (is_stop_request(set_light_color) && dwell >= GreenLast) begin
                        state_d = StYellow;
                    end
                end
                StYellow: begin
                    if (dwell >= YellowLast) begin
`ifdef LIGHT_DRV_ALL_RED_EN
                        state_d = StClear;
`else
                        state_d = StRed;
`endif
                    end
                end
`ifdef LIGHT_DRV_ALL_RED_EN
                StClear: begin
                    if (dwell >= ClearLast) begin
                        state_d = StRed;
                    end
                end
`endif
                default: state_d = StRed;
            endcase
        end
    end

    // Outputs decoded from the next state so the registered lamps line up with state_q.
    always_comb begin
        color_d  = COLOR_RED;
        red_d    = 1'b1;
        yellow_d = 1'b0;
        green_d  = 1'b0;
        busy_d   = 1'b0;
        unique case (state_d)
            StGreen: begin
                color_d = COLOR_GREEN;
                red_d   = 1'b0;
                green_d = 1'b1;
            end
            StYellow: begin
                color_d  = COLOR_YELLOW;
                red_d    = 1'b0;
                yellow_d = 1'b1;
                busy_d   = 1'b1;
            end
`ifdef LIGHT_DRV_ALL_RED_EN
            StClear: begin
                // All-red clearance is not a settled red yet.
                color_d = COLOR_YELLOW;
                busy_d  = 1'b1;
            end
`endif
            default: begin
                color_d = COLOR_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StRed;
            current_light_state <= COLOR_RED;
            lamp_red            <= 1'b1;
            lamp_yellow         <= 1'b0;
            lamp_green          <= 1'b0;
            busy                <= 1'b0;
            cmd_err             <= 1'b0;
        end else begin
            state_q             <= state_d;
            current_light_state <= color_d;
            lamp_red            <= red_d;
            lamp_yellow         <= yellow_d;
            lamp_green          <= green_d;
            busy                <= busy_d;
            cmd_err             <= (set_light_color == COLOR_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_light_lamp_driver.sv
// Scoreboard bench for light_lamp_driver: directed plan sequences followed by random requests,
// checked every cycle against a colour/visible-time reference model.
module tb_light_lamp_driver;

    localparam int MinRed   = 2;
    localparam int MinGreen = 8;
    localparam int Yellow   = 4;
    localparam int Clear    = 3;
`ifdef LIGHT_DRV_ALL_RED_EN
    localparam bit AllRed = 1'b1;
`else
    localparam bit AllRed = 1'b0;
`endif

    // Model colours
    localparam int MRed    = 0;
    localparam int MGreen  = 1;
    localparam int MYellow = 2;
    localparam int MClear  = 3;

    typedef struct packed {
        logic [1:0] state;
        logic       red;
        logic       yellow;
        logic       green;
        logic       busy;
        logic       err;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] set_light_color;
    logic [1:0] current_light_state;
    logic       lamp_red, lamp_yellow, lamp_green, busy, cmd_err;

    always #5 clk = ~clk;

    light_lamp_driver #(
        .CNT_W            (8),
        .MIN_RED_CYCLES   (MinRed),
        .MIN_GREEN_CYCLES (MinGreen),
        .YELLOW_CYCLES    (Yellow),
        .CLEAR_CYCLES     (Clear)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .set_light_color     (set_light_color),
        .current_light_state (current_light_state),
        .lamp_red            (lamp_red),
        .lamp_yellow         (lamp_yellow),
        .lamp_green          (lamp_green),
        .busy                (busy),
        .cmd_err             (cmd_err)
    );

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    bit   started  = 1'b0;

    int m_col   = MRed;
    int m_shown = 1;  // cycles the current colour has been visible, including this one

    function automatic obs_t expected_obs(input int col, input bit err);
        obs_t o;
        o.err = err;
        case (col)
            MGreen:  begin o.state = 2'd3; o.red = 0; o.yellow = 0; o.green = 1; o.busy = 0; end
            MYellow: begin o.state = 2'd1; o.red = 0; o.yellow = 1; o.green = 0; o.busy = 1; end
            MClear:  begin o.state = 2'd1; o.red = 1; o.yellow = 0; o.green = 0; o.busy = 1; end
            default: begin o.state = 2'd0; o.red = 1; o.yellow = 0; o.green = 0; o.busy = 0; end
        endcase
        return o;
    endfunction

    // Advance the model across one clock edge and queue what the DUT must show afterwards.
    task automatic model_step(input logic r, input logic [1:0] s);
        int next_col;
        next_col = m_col;
        if (r) begin
            next_col = MRed;
            m_col    = -1;  // force "entered new colour"
        end else begin
            case (m_col)
                MRed:    if (s == 2'd3 && m_shown >= MinRed) next_col = MGreen;
                MGreen:  if ((s == 2'd0 || s == 2'd1) && m_shown >= MinGreen) next_col = MYellow;
                MYellow: if (m_shown == Yellow) next_col = AllRed ? MClear : MRed;
                MClear:  if (m_shown == Clear) next_col = MRed;
                default: next_col = MRed;
            endcase
        end
        if (next_col == m_col) m_shown++;
        else m_shown = 1;
        m_col = next_col;
        exp_q.push_back(expected_obs(m_col, !r && s == 2'd2));
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst             = r;
            set_light_color = s;
            started         = 1'b1;
            model_step(r, s);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (started) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow cycle=%0d actual=empty required=entry", cycle);
                end else begin
                    e = exp_q.pop_front();
                    a = '{current_light_state, lamp_red, lamp_yellow, lamp_green, busy, cmd_err};
                    if (a !== e) begin
                        failures++;
                        $display("FAIL outputs cycle=%0d actual{st,r,y,g,busy,err}=%b required=%b",
                                 cycle, a, e);
                    end
                end
            end
        end
    end

    initial begin
        int seg, req, pick;
        rst             = 1'b1;
        set_light_color = 2'd3;

        // Reset with green requested, then first green and minimum green.
        drive(1'b1, 2'd3, 2);
        drive(1'b0, 2'd3, 5);
        drive(1'b0, 2'd0, 16);
        // Ignored yellow request and illegal code in red.
        drive(1'b0, 2'd1, 5);
        drive(1'b0, 2'd2, 2);
        drive(1'b0, 2'd0, 3);
        // Green request raised during yellow and held.
        drive(1'b0, 2'd3, 12);
        drive(1'b0, 2'd0, 1);
        drive(1'b0, 2'd3, 14);
        // Reset in the middle of yellow.
        drive(1'b0, 2'd0, 2);
        drive(1'b1, 2'd0, 1);
        drive(1'b0, 2'd0, 4);
        // Long green to push the dwell counter into saturation.
        drive(1'b0, 2'd3, 300);
        drive(1'b0, 2'd1, 12);

        for (int k = 0; k < 250; k++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 40)      req = 3;
            else if (pick < 65) req = 0;
            else if (pick < 85) req = 1;
            else                req = 2;
            seg = int'($urandom_range(1, 14));
            for (int j = 0; j < seg; j++) begin
                drive(($urandom_range(0, 59) == 0), 2'(req), 1);
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
